// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
// Build option: SERIAL_CMP_SIGNED_EN selects two's-complement operands.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    FIRST,
    SCAN_EQ,
    SCAN_DEC,
    HOLD
  } cmp_state_e;

  localparam logic [1:0] RES_EQ = 2'd0;
  localparam logic [1:0] RES_GT = 2'd1;
  localparam logic [1:0] RES_LT = 2'd2;

  localparam int MAX_BITS_DEF = 8;

  // One beat's verdict; inv flips the sense for a sign bit.
  function automatic logic [1:0] beat_res(
    input logic a,
    input logic b,
    input logic inv
  );
    if (a == b) return RES_EQ;
    return (a ^ inv) ? RES_GT : RES_LT;
  endfunction

endpackage

// File: rtl/serial_cmp_bitcnt.sv
// Saturating beat counter for the serial comparator.
// Reports when it sits at the saturation value.
module serial_cmp_bitcnt
  import serial_cmp_pkg::*;
#(
  parameter int MAX_BITS = MAX_BITS_DEF,
  parameter int CNT_W    = $clog2(MAX_BITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             at_max_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign at_max_o = (cnt_q == CNT_W'(MAX_BITS));
  assign cnt_o    = cnt_q;

  // Next count: clear wins, otherwise step until saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_comparator.sv
// Bit-serial MSB-first magnitude comparator with held 3-way result.
// Define SERIAL_CMP_SIGNED_EN for two's-complement operands.
module serial_comparator
  import serial_cmp_pkg::*;
#(
  parameter int MAX_BITS = MAX_BITS_DEF,
  parameter int CNT_W    = $clog2(MAX_BITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a_bit,
  input  logic             b_bit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             A_greater,
  output logic             A_equal,
  output logic             A_less,
  output logic [CNT_W-1:0] bit_count,
  output logic             len_err
);

  cmp_state_e state_q;
  logic [1:0] res_q;
  logic       vld_q;
  logic       gt_q;
  logic       eq_q;
  logic       lt_q;
  logic       lerr_q;

  logic       acc;
  logic       done;
  logic       at_max;
  logic       sign_beat;
  logic [1:0] frame_res;

  assign in_ready = (state_q != HOLD);
  assign acc      = in_valid && in_ready;
  assign done     = vld_q && out_ready;

`ifdef SERIAL_CMP_SIGNED_EN
  assign sign_beat = (state_q == FIRST);
`else
  assign sign_beat = 1'b0;
`endif

  // Once decided, later beats cannot change the verdict.
  always_comb begin
    frame_res = beat_res(a_bit, b_bit, sign_beat);
    if (state_q == SCAN_DEC) begin
      frame_res = res_q;
    end
  end

  serial_cmp_bitcnt #(
    .MAX_BITS (MAX_BITS),
    .CNT_W    (CNT_W)
  ) u_bitcnt (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (acc),
    .clr_i    (done),
    .cnt_o    (bit_count),
    .at_max_o (at_max)
  );

  // Overlength flag, cleared with the result handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lerr_q <= 1'b0;
    end else if (done) begin
      lerr_q <= 1'b0;
    end else if (acc && at_max) begin
      lerr_q <= 1'b1;
    end
  end

  // Frame FSM with registered result flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FIRST;
      res_q   <= RES_EQ;
      vld_q   <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      unique case (state_q)
        FIRST, SCAN_EQ, SCAN_DEC: begin
          if (acc) begin
            res_q <= frame_res;
            if (in_last) begin
              state_q <= HOLD;
              vld_q   <= 1'b1;
              gt_q    <= (frame_res == RES_GT);
              eq_q    <= (frame_res == RES_EQ);
              lt_q    <= (frame_res == RES_LT);
            end else if (frame_res == RES_EQ) begin
              state_q <= SCAN_EQ;
            end else begin
              state_q <= SCAN_DEC;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q <= FIRST;
            res_q   <= RES_EQ;
            vld_q   <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= FIRST;
        end
      endcase
    end
  end

  assign out_valid = vld_q;
  assign A_greater = gt_q;
  assign A_equal   = eq_q;
  assign A_less    = lt_q;
  assign len_err   = lerr_q;

endmodule
